// File: rtl/reaction_round_seq.sv
// Multi-round sequencer for the reaction-game core: runs 2**LOG2_ROUNDS rounds per start press,
// drives the core start pulse and random delay, and accumulates best/average/early statistics.
module reaction_round_seq #(
  parameter int unsigned LOG2_ROUNDS = 2,
  parameter logic [15:0] MIN_DELAY   = 16'd1000,
  parameter logic [15:0] DELAY_MASK  = 16'h07FF,
  parameter logic [15:0] GAP_MS      = 16'd500,
  parameter logic [15:0] PENALTY_MS  = 16'd1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_btn,
  input  logic                   ms_tick,
  input  logic                   show_time,
  input  logic                   early_error,
  input  logic [15:0]            react_ms,
  output logic                   core_start,
  output logic [15:0]            rand_delay,
  output logic                   busy,
  output logic                   done,
  output logic [LOG2_ROUNDS:0]   round_idx,
  output logic [15:0]            best_ms,
  output logic                   best_valid,
  output logic [15:0]            avg_ms,
  output logic [LOG2_ROUNDS:0]   early_cnt
);

  localparam int unsigned SumW   = 16 + LOG2_ROUNDS;
  localparam int unsigned IdxW   = LOG2_ROUNDS + 1;
  localparam int unsigned Rounds = 2 ** LOG2_ROUNDS;
  localparam logic [IdxW-1:0] RoundsIdx = Rounds[IdxW-1:0];
  localparam logic [IdxW-1:0] IdxOne    = {{(IdxW-1){1'b0}}, 1'b1};
  localparam logic [15:0]     LfsrSeed  = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StRecord,
    StClear,
    StGap,
    StDone
  } state_e;

  state_e          state_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            core_start_q;
  logic [15:0]     rand_delay_q;
  logic            busy_q, done_q;
  logic [IdxW-1:0] round_idx_q, early_cnt_q;
  logic [15:0]     best_q, avg_q;
  logic            best_valid_q;
  logic [SumW-1:0] sum_q;
  logic [15:0]     gap_q;
  logic            was_early_q;
  logic [15:0]     react_q;
  logic [SumW-1:0] avg_full;

  // Fibonacci LFSR, taps 16,14,13,11; left-shifting so bit 15 is tap 16.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    avg_full = sum_q >> LOG2_ROUNDS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lfsr_q       <= LfsrSeed;
      core_start_q <= 1'b0;
      rand_delay_q <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      round_idx_q  <= '0;
      best_q       <= 16'hFFFF;
      best_valid_q <= 1'b0;
      avg_q        <= 16'd0;
      early_cnt_q  <= '0;
      sum_q        <= '0;
      gap_q        <= 16'd0;
      was_early_q  <= 1'b0;
      react_q      <= 16'd0;
    end else begin
      lfsr_q       <= lfsr_d;
      core_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_btn) begin
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            round_idx_q  <= '0;
            best_q       <= 16'hFFFF;
            best_valid_q <= 1'b0;
            avg_q        <= 16'd0;
            early_cnt_q  <= '0;
            sum_q        <= '0;
            gap_q        <= 16'd0;
            state_q      <= StStart;
          end
        end
        StStart: begin
          core_start_q <= 1'b1;
          rand_delay_q <= MIN_DELAY + (lfsr_q & DELAY_MASK);
          state_q      <= StRun;
        end
        StRun: begin
          // Early wins when the core reports both at once.
          if (show_time || early_error) begin
            was_early_q <= early_error;
            react_q     <= react_ms;
            state_q     <= StRecord;
          end
        end
        StRecord: begin
          if (was_early_q) begin
            sum_q       <= sum_q + SumW'(PENALTY_MS);
            early_cnt_q <= early_cnt_q + IdxOne;
          end else begin
            sum_q        <= sum_q + SumW'(react_q);
            best_valid_q <= 1'b1;
            if (react_q < best_q) begin
              best_q <= react_q;
            end
          end
          round_idx_q <= round_idx_q + IdxOne;
          state_q     <= StClear;
        end
        StClear: begin
          core_start_q <= 1'b1;
          gap_q        <= GAP_MS;
          if (round_idx_q == RoundsIdx) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            avg_q   <= (|avg_full[SumW-1:16]) ? 16'hFFFF : avg_full[15:0];
            state_q <= StDone;
          end else begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (ms_tick) begin
            if (gap_q == 16'd0) begin
              state_q <= StStart;
            end else begin
              gap_q <= gap_q - 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign rand_delay = rand_delay_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign round_idx  = round_idx_q;
  assign best_ms    = best_q;
  assign best_valid = best_valid_q;
  assign avg_ms     = avg_q;
  assign early_cnt  = early_cnt_q;

endmodule

// File: tb/tb_reaction_round_seq.sv
// Bench for reaction_round_seq: table of whole-game vectors, randomized games scored by a
// round-level statistics model, gap timing, ignored presses and a mid-game reset.
module tb_reaction_round_seq;

  localparam int unsigned NR    = 4;
  localparam logic [15:0] MIN_D = 16'd1000;
  localparam logic [15:0] MASK  = 16'h07FF;
  localparam logic [15:0] GAP   = 16'd3;
  localparam logic [15:0] PEN   = 16'd1000;

  logic        clk, rst_n, start_btn, ms_tick, show_time, early_error;
  logic [15:0] react_ms;
  logic        core_start, busy, done, best_valid;
  logic [15:0] rand_delay, best_ms, avg_ms;
  logic [2:0]  round_idx, early_cnt;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int dbl_cnt = 0;
  logic prev_cs = 1'b0;
  logic [15:0] lfsr_m, lfsr_prev;

  typedef struct packed {
    logic [3:0][15:0] react;
    logic [3:0]       early_m;
    logic [3:0]       both_m;
    logic [15:0]      best;
    logic             bv;
    logic [15:0]      avg;
    logic [2:0]       ecnt;
  } vec_t;

  vec_t tbl [7];

  reaction_round_seq #(.GAP_MS(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .ms_tick     (ms_tick),
    .show_time   (show_time),
    .early_error (early_error),
    .react_ms    (react_ms),
    .core_start  (core_start),
    .rand_delay  (rand_delay),
    .busy        (busy),
    .done        (done),
    .round_idx   (round_idx),
    .best_ms     (best_ms),
    .best_valid  (best_valid),
    .avg_ms      (avg_ms),
    .early_cnt   (early_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Reference LFSR plus core_start pulse bookkeeping, sampled at the active edge.
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= rst_n ? lfsr_next(lfsr_m) : 16'hACE1;
    prev_cs   <= core_start;
    if (core_start) pulses <= pulses + 1;
    if (core_start && prev_cs) dbl_cnt <= dbl_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d, input logic [3:0] em, bm,
                              input logic [15:0] best, input logic bv, input logic [15:0] avg,
                              input logic [2:0] ec);
    vec_t v;
    v.react = {d, c, b, a};
    v.early_m = em; v.both_m = bm;
    v.best = best; v.bv = bv; v.avg = avg; v.ecnt = ec;
    return v;
  endfunction

  // Game-level statistics straight from the scoring rules.
  function automatic vec_t model(input logic [3:0][15:0] react, input logic [3:0] em,
                                 input logic [3:0] bm);
    vec_t v;
    int sum = 0;
    int a;
    v.react = react; v.early_m = em; v.both_m = bm;
    v.best = 16'hFFFF; v.bv = 1'b0; v.ecnt = 3'd0;
    for (int i = 0; i < NR; i++) begin
      if (em[i]) begin
        sum += int'(PEN);
        v.ecnt++;
      end else begin
        sum += int'(react[i]);
        if (react[i] < v.best) v.best = react[i];
        v.bv = 1'b1;
      end
    end
    a = sum / NR;
    v.avg = (a > 65535) ? 16'hFFFF : a[15:0];
    return v;
  endfunction

  task automatic wait_cs(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!core_start && waited < budget);
    chk("core_start_seen", core_start, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {core_start, busy, done}, 3'b000);
    chk({tag, "_delay"}, rand_delay, 16'd0);
    chk({tag, "_stats"}, {round_idx, best_ms, best_valid, avg_ms, early_cnt},
        {3'd0, 16'hFFFF, 1'b0, 16'd0, 3'd0});
  endtask

  task automatic play_round(input int r, input logic [15:0] react, input logic early,
                            input logic both, input logic inject);
    int w;
    wait_cs(200, w);
    if (r > 0) chk("gap_latency", w, 1);
    chk("rand_delay", rand_delay, MIN_D + (lfsr_prev & MASK));
    @(negedge clk);
    chk("start_width", core_start, 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    if (inject) begin
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
    end
    if (early) begin
      early_error = 1'b1;
      show_time   = both;
      react_ms    = 16'($urandom);
    end else begin
      show_time = 1'b1;
      react_ms  = react;
    end
    wait_cs(50, w);
    show_time = 1'b0; early_error = 1'b0; react_ms = 16'($urandom);
    chk("round_idx", round_idx, r + 1);
    if (r < NR - 1) begin
      ms_tick = 1'b1;
      for (int k = 1; k <= int'(GAP) + 1; k++) begin
        @(negedge clk);
        start_btn = inject && (k == 1);
        chk("gap_hold", core_start, 0);
      end
      ms_tick = 1'b0; start_btn = 1'b0;
    end
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("clr_busy_done", {busy, done}, 2'b10);
    chk("clr_stats", {round_idx, best_ms, best_valid, avg_ms, early_cnt},
        {3'd0, 16'hFFFF, 1'b0, 16'd0, 3'd0});
  endtask

  task automatic run_game(input vec_t v, input logic inject);
    int p0, n;
    p0 = pulses;
    start_game();
    for (int r = 0; r < NR; r++)
      play_round(r, v.react[r], v.early_m[r], v.both_m[r], inject && (r == 1));
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("done", {busy, done, round_idx}, {1'b0, 1'b1, 3'd4});
    chk("best", {best_valid, best_ms}, {v.bv, v.best});
    chk("avg", avg_ms, v.avg);
    chk("early_cnt", early_cnt, v.ecnt);
    @(negedge clk);
    chk("pulse_count", pulses - p0, 8);
  endtask

  initial begin
    vec_t rv;
    logic [3:0][15:0] rr;
    logic [3:0] em;
    int w;
    rst_n = 1'b0; start_btn = 1'b0; ms_tick = 1'b0;
    show_time = 1'b0; early_error = 1'b0; react_ms = 16'd0;

    tbl[0] = mk(16'd250, 16'd180, 16'd300, 16'd210, 4'b0000, 4'b0000, 16'd180, 1'b1, 16'd235, 3'd0);
    tbl[1] = mk(16'd200, 16'd0, 16'd400, 16'd0, 4'b1010, 4'b0000, 16'd200, 1'b1, 16'd650, 3'd2);
    tbl[2] = mk(16'd0, 16'd0, 16'd0, 16'd0, 4'b1111, 4'b0000, 16'hFFFF, 1'b0, 16'd1000, 3'd4);
    tbl[3] = mk(16'd100, 16'd500, 16'd120, 16'd130, 4'b0001, 4'b0001, 16'd120, 1'b1, 16'd437, 3'd1);
    tbl[4] = mk(16'd300, 16'd300, 16'd250, 16'd250, 4'b0000, 4'b0000, 16'd250, 1'b1, 16'd275, 3'd0);
    tbl[5] = mk(16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 4'b0000, 4'b0000, 16'd0, 1'b1, 16'd49151, 3'd0);
    tbl[6] = mk(16'hFFFF, 16'd0, 16'd0, 16'd0, 4'b1110, 4'b0000, 16'hFFFF, 1'b1, 16'd17133, 3'd3);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    chk("idle_quiet", {core_start, busy}, 2'b00);

    for (int i = 0; i < 7; i++) run_game(tbl[i], i == 3);

    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < NR; i++)
        rr[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3000));
      em = 4'($urandom_range(0, 15));
      rv = model(rr, em, 4'($urandom) & em);
      run_game(rv, g[0]);
    end

    // Abandon a game during the third round's RUN.
    start_game();
    play_round(0, 16'd300, 1'b0, 1'b0, 1'b0);
    play_round(1, 16'd300, 1'b1, 1'b0, 1'b0);
    wait_cs(200, w);
    chk("rand_delay_r3", rand_delay, MIN_D + (lfsr_prev & MASK));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    repeat (4) @(negedge clk);
    chk("midreset_idle", {core_start, busy}, 2'b00);
    run_game(tbl[0], 1'b0);
    run_game(tbl[1], 1'b0);

    chk("no_back_to_back", dbl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
